// File: rtl/fft_data_adapter_tx.sv
// FFT source-port return adapter: applies the block exponent, rounds half-up and saturates each
// component to the symbol width, checks packet framing, and re-emits {real, imag} as Avalon-ST.
module fft_data_adapter_tx #(
    parameter int INPUT_SYMBOL_WIDTH  = 18,
    parameter int OUTPUT_SYMBOL_WIDTH = 16,
    parameter int EXP_WIDTH           = 6,
    parameter int USE_EXPONENT        = 1,
    parameter int MAX_SHIFT           = 8,
    parameter int FFT_LENGTH          = 1024
) (
    input  logic                                        clock_clk,
    input  logic                                        reset_reset_n,
    input  logic [2*INPUT_SYMBOL_WIDTH+EXP_WIDTH-1:0]   asi_in_data,
    input  logic                                        asi_in_valid,
    input  logic                                        asi_in_startofpacket,
    input  logic                                        asi_in_endofpacket,
    output logic                                        asi_in_ready,
    output logic [2*OUTPUT_SYMBOL_WIDTH-1:0]            aso_out_data,
    output logic                                        aso_out_valid,
    output logic                                        aso_out_startofpacket,
    output logic                                        aso_out_endofpacket,
    input  logic                                        aso_out_ready,
    output logic                                        pkt_error,
    output logic                                        sat_flag
);

    localparam int IW   = INPUT_SYMBOL_WIDTH;
    localparam int OW   = OUTPUT_SYMBOL_WIDTH;
    localparam int W    = IW + MAX_SHIFT + 1;
    localparam int FRAC = IW - OW;
    localparam int HALF = 1 << (FRAC - 1);
    localparam int SW   = EXP_WIDTH + 1;
    localparam int CW   = $clog2(FFT_LENGTH + 1) + 1;

    localparam logic signed [SW-1:0] SHIFT_MAX = SW'(MAX_SHIFT);
    localparam logic signed [W-1:0]  SAT_MAX   = W'((1 << (OW - 1)) - 1);
    localparam logic signed [W-1:0]  SAT_MIN   = ~SAT_MAX;

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t                 state, state_next;
    logic [CW-1:0]          count, count_next, count_inc;
    logic                   err_next, fwd;

    logic signed [IW-1:0]        in_re, in_im;
    logic signed [EXP_WIDTH-1:0] in_exp;
    logic signed [SW-1:0]        shift_raw, shift;

    logic                   s1_valid, s1_sop, s1_eop;
    logic signed [W-1:0]    s1_re, s1_im;
    logic [OW:0]            re_sat, im_sat;
    logic                   s2_free, s1_advance, accept, s1_load;

    assign in_re  = asi_in_data[2*IW+EXP_WIDTH-1 -: IW];
    assign in_im  = asi_in_data[IW+EXP_WIDTH-1 -: IW];
    assign in_exp = asi_in_data[EXP_WIDTH-1:0];

    // Shift left by s, or arithmetic right by -s; the wide intermediate cannot overflow.
    function automatic logic signed [W-1:0] scale_round(input logic signed [IW-1:0] x,
                                                        input logic signed [SW-1:0] sh);
        logic signed [W-1:0] ext, scaled;
        logic [SW-1:0]       rsh;
        ext = W'(x);
        rsh = -sh;
        if (sh < 0) scaled = ext >>> rsh;
        else        scaled = ext <<< sh;
        return (scaled + W'(HALF)) >>> FRAC;
    endfunction

    // Returns {clamped, value}.
    function automatic logic [OW:0] saturate(input logic signed [W-1:0] v);
        logic [OW:0] r;
        if (v > SAT_MAX)      r = {1'b1, SAT_MAX[OW-1:0]};
        else if (v < SAT_MIN) r = {1'b1, SAT_MIN[OW-1:0]};
        else                  r = {1'b0, v[OW-1:0]};
        return r;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        shift_raw = '0;
        if (USE_EXPONENT != 0) shift_raw = -SW'(in_exp);
        shift = shift_raw;
        if (shift_raw > SHIFT_MAX) shift = SHIFT_MAX;
    end

    assign s2_free      = !aso_out_valid || aso_out_ready;
    assign s1_advance   = s1_valid && s2_free;
    assign asi_in_ready = !s1_valid || s1_advance;
    assign accept       = asi_in_valid && asi_in_ready;
    assign s1_load      = accept && fwd;
    assign re_sat       = saturate(s1_re);
    assign im_sat       = saturate(s1_im);

    // Framing: a beat without sop outside a packet is consumed but never forwarded.
    always_comb begin
        state_next = state;
        count_next = count;
        err_next   = 1'b0;
        fwd        = 1'b0;
        count_inc  = (count == '1) ? count : count + 1'b1;
        if (accept) begin
            if (asi_in_startofpacket) begin
                fwd        = 1'b1;
                err_next   = (state == IN_PKT);
                state_next = IN_PKT;
                count_next = CW'(1);
                if (asi_in_endofpacket) begin
                    err_next   = err_next || (FFT_LENGTH != 1);
                    state_next = IDLE;
                    count_next = '0;
                end
            end else if (state == IDLE) begin
                err_next = 1'b1;
            end else begin
                fwd        = 1'b1;
                count_next = count_inc;
                if (asi_in_endofpacket) begin
                    err_next   = (count_inc != CW'(FFT_LENGTH));
                    state_next = IDLE;
                    count_next = '0;
                end
            end
        end
    end

    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state     <= IDLE;
            count     <= '0;
            pkt_error <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state     <= state_next;
            count     <= count_next;
            pkt_error <= err_next;
        end
    end

    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            s1_valid <= 1'b0;
            s1_sop   <= 1'b0;
            s1_eop   <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_sop   <= asi_in_startofpacket;
            s1_eop   <= asi_in_endofpacket;
            s1_re    <= scale_round(in_re, shift);
            s1_im    <= scale_round(in_im, shift);
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Output stage only loads when free, so data/sop/eop hold steady under backpressure.
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            aso_out_valid         <= 1'b0;
            aso_out_startofpacket <= 1'b0;
            aso_out_endofpacket   <= 1'b0;
            aso_out_data          <= '0;
            sat_flag              <= 1'b0;
        end else begin
            if (s1_advance) begin
                aso_out_valid         <= 1'b1;
                aso_out_startofpacket <= s1_sop;
                aso_out_endofpacket   <= s1_eop;
                aso_out_data          <= {re_sat[OW-1:0], im_sat[OW-1:0]};
            end else if (aso_out_ready) begin
                aso_out_valid <= 1'b0;
            end
            // An sop can only be accepted once older beats have left S1, so clearing wins.
            if (accept && asi_in_startofpacket)      sat_flag <= 1'b0;
            else if (s1_advance && (re_sat[OW] || im_sat[OW])) sat_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fft_data_adapter_tx.sv
// Randomized self-checking bench for fft_data_adapter_tx with a queue-based arithmetic and
// framing reference model plus directed scenario tasks.
module tb_fft_data_adapter_tx;

    localparam int IN    = 18;
    localparam int OUT   = 16;
    localparam int EXPW  = 6;
    localparam int LEN   = 4;
    localparam int DW_IN = 2*IN + EXPW;
    localparam int DW_OUT = 2*OUT;

    logic                clock_clk;
    logic                reset_reset_n;
    logic [DW_IN-1:0]    asi_in_data;
    logic                asi_in_valid;
    logic                asi_in_startofpacket;
    logic                asi_in_endofpacket;
    logic                asi_in_ready;
    logic [DW_OUT-1:0]   aso_out_data;
    logic                aso_out_valid;
    logic                aso_out_startofpacket;
    logic                aso_out_endofpacket;
    logic                aso_out_ready;
    logic                pkt_error;
    logic                sat_flag;

    fft_data_adapter_tx #(
        .INPUT_SYMBOL_WIDTH (IN),
        .OUTPUT_SYMBOL_WIDTH(OUT),
        .EXP_WIDTH          (EXPW),
        .USE_EXPONENT       (1),
        .MAX_SHIFT          (8),
        .FFT_LENGTH         (LEN)
    ) dut (
        .clock_clk            (clock_clk),
        .reset_reset_n        (reset_reset_n),
        .asi_in_data          (asi_in_data),
        .asi_in_valid         (asi_in_valid),
        .asi_in_startofpacket (asi_in_startofpacket),
        .asi_in_endofpacket   (asi_in_endofpacket),
        .asi_in_ready         (asi_in_ready),
        .aso_out_data         (aso_out_data),
        .aso_out_valid        (aso_out_valid),
        .aso_out_startofpacket(aso_out_startofpacket),
        .aso_out_endofpacket  (aso_out_endofpacket),
        .aso_out_ready        (aso_out_ready),
        .pkt_error            (pkt_error),
        .sat_flag             (sat_flag)
    );

    initial clock_clk = 1'b0;
    always #5 clock_clk = ~clock_clk;

    typedef struct {
        logic [DW_OUT-1:0] data;
        logic              sop;
        logic              eop;
    } beat_t;

    beat_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    bit    in_pkt = 0;
    int    cnt = 0;
    bit    err_pend = 0;

    function automatic longint floor_div(input longint a, input longint b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    // Real-number view: x * 2^s (s clamped to 8), round half-up to 2^-2 steps, then clip.
    function automatic int ref_comp(input int x, input int e);
        int     s;
        longint v, r;
        s = -e;
        if (s > 8) s = 8;
        if (s >= 0) v = longint'(x) * (longint'(1) << s);
        else        v = floor_div(longint'(x), longint'(1) << (-s));
        r = floor_div(v + 2, 4);
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    task automatic model_accept();
        int    re, im, ex, ore, oim;
        bit    fwd, err;
        beat_t b;
        re  = int'($signed(asi_in_data[DW_IN-1 -: IN]));
        im  = int'($signed(asi_in_data[IN+EXPW-1 -: IN]));
        ex  = int'($signed(asi_in_data[EXPW-1:0]));
        err = 0;
        fwd = 1;
        if (asi_in_startofpacket) begin
            err = in_pkt; in_pkt = 1; cnt = 1;
        end else if (!in_pkt) begin
            err = 1; fwd = 0;
        end else begin
            cnt++;
        end
        if (fwd && asi_in_endofpacket) begin
            if (cnt != LEN) err = 1;
            in_pkt = 0;
        end
        if (fwd) begin
            ore    = ref_comp(re, ex);
            oim    = ref_comp(im, ex);
            b.data = {16'(ore), 16'(oim)};
            b.sop  = asi_in_startofpacket;
            b.eop  = asi_in_endofpacket;
            exp_q.push_back(b);
        end
        err_pend = err;
    endtask

    task automatic monitor();
        beat_t b;
        forever begin
            @(negedge clock_clk);
            if (!reset_reset_n) begin
                exp_q.delete();
                in_pkt = 0; cnt = 0; err_pend = 0;
                continue;
            end
            tests++;
            if (pkt_error !== err_pend) begin
                fails++;
                $display("FAIL pkt_error t=%0t got=%0b want=%0b", $time, pkt_error, err_pend);
            end
            err_pend = 0;
            if (aso_out_valid && aso_out_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat t=%0t got=%h want=none", $time, aso_out_data);
                end else begin
                    b = exp_q.pop_front();
                    if (aso_out_data !== b.data || aso_out_startofpacket !== b.sop ||
                        aso_out_endofpacket !== b.eop) begin
                        fails++;
                        $display("FAIL out_beat t=%0t got=%h/%0b/%0b want=%h/%0b/%0b", $time,
                                 aso_out_data, aso_out_startofpacket, aso_out_endofpacket,
                                 b.data, b.sop, b.eop);
                    end
                end
            end
            if (asi_in_valid && asi_in_ready) model_accept();
        end
    endtask

    task automatic drive_beat(input int re, input int im, input int ex, input bit sop, input bit eop);
        bit done;
        done = 0;
        asi_in_data          = {IN'(re), IN'(im), EXPW'(ex)};
        asi_in_valid         = 1'b1;
        asi_in_startofpacket = sop;
        asi_in_endofpacket   = eop;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clock_clk);
            if (asi_in_ready) begin
                @(posedge clock_clk);
                #1;
                done = 1;
            end
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL drive_timeout got=no_ready want=ready");
        end
        asi_in_valid         = 1'b0;
        asi_in_startofpacket = 1'b0;
        asi_in_endofpacket   = 1'b0;
    endtask

    task automatic wait_out(input logic [DW_OUT-1:0] want, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock_clk);
            if (aso_out_valid && aso_out_ready) seen = 1;
        end
        tests++;
        if (!seen || aso_out_data !== want) begin
            fails++;
            $display("FAIL %s got=%h seen=%0b want=%h", name, aso_out_data, seen, want);
        end
        @(posedge clock_clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && (exp_q.size() != 0 || aso_out_valid); i++) @(negedge clock_clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain got=%0d_pending want=0", name, exp_q.size());
        end
        @(posedge clock_clk);
        #1;
    endtask

    task automatic test_reset();
        reset_reset_n = 1'b0;
        repeat (2) @(negedge clock_clk);
        tests++;
        if (aso_out_valid !== 1'b0 || aso_out_data !== '0 || aso_out_startofpacket !== 1'b0 ||
            aso_out_endofpacket !== 1'b0 || pkt_error !== 1'b0 || sat_flag !== 1'b0 ||
            asi_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state got=v%0b d%h s%0b e%0b p%0b f%0b r%0b want=all0_ready1",
                     aso_out_valid, aso_out_data, aso_out_startofpacket, aso_out_endofpacket,
                     pkt_error, sat_flag, asi_in_ready);
        end
        @(posedge clock_clk);
        #1;
        reset_reset_n = 1'b1;
        @(posedge clock_clk);
        #1;
    endtask

    task automatic test_basic();
        drive_beat(5, -6, 0, 1, 0);
        @(negedge clock_clk);
        tests++;
        if (aso_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL latency_early got=%0b want=0", aso_out_valid);
        end
        @(negedge clock_clk);
        tests++;
        if (aso_out_valid !== 1'b1 || aso_out_data !== 32'h0001_FFFF || sat_flag !== 1'b0) begin
            fails++;
            $display("FAIL basic_round got=v%0b %h f%0b want=v1 0001ffff f0",
                     aso_out_valid, aso_out_data, sat_flag);
        end
        @(posedge clock_clk);
        #1;
        drive_beat(1, 2, 0, 0, 0);
        drive_beat(3, 4, 0, 0, 0);
        drive_beat(-5, 7, 0, 0, 1);
        drain("basic");
    endtask

    task automatic test_saturation();
        drive_beat(131071, -131072, -2, 1, 0);
        wait_out(32'h7FFF_8000, "saturate");
        tests++;
        if (sat_flag !== 1'b1) begin
            fails++;
            $display("FAIL sat_set got=%0b want=1", sat_flag);
        end
        for (int i = 0; i < 3; i++) drive_beat(0, 0, 0, 0, i == 2);
        drain("sat");
        repeat (3) @(negedge clock_clk);
        tests++;
        if (sat_flag !== 1'b1) begin
            fails++;
            $display("FAIL sat_held got=%0b want=1", sat_flag);
        end
        @(posedge clock_clk);
        #1;
        drive_beat(100, -100, 0, 1, 0);
        @(negedge clock_clk);
        tests++;
        if (sat_flag !== 1'b0) begin
            fails++;
            $display("FAIL sat_clear got=%0b want=0", sat_flag);
        end
        @(posedge clock_clk);
        #1;
        for (int i = 0; i < 3; i++) drive_beat(i, -i, 0, 0, i == 2);
        drain("sat2");
        tests++;
        if (sat_flag !== 1'b0) begin
            fails++;
            $display("FAIL sat_clean_pkt got=%0b want=0", sat_flag);
        end
    endtask

    task automatic test_shift_clamp();
        drive_beat(1, 0, -12, 1, 0);
        wait_out(32'h0040_0000, "shift_clamp");
        drive_beat(-64, 0, 3, 0, 0);
        wait_out(32'hFFFE_0000, "right_shift");
        drive_beat(0, 0, 0, 0, 0);
        drive_beat(0, 0, 0, 0, 1);
        drain("clamp");
    endtask

    task automatic test_backpressure();
        fork
            begin
                for (int b = 0; b < 4; b++)
                    drive_beat(int'($urandom_range(4000)) - 2000, int'($urandom_range(4000)) - 2000,
                               int'($urandom_range(8)) - 4, b == 0, b == 3);
            end
            begin
                @(posedge clock_clk);
                @(posedge clock_clk);
                #1;
                aso_out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clock_clk);
                    tests++;
                    if (exp_q.size() == 0 || aso_out_valid !== 1'b1 ||
                        aso_out_data !== exp_q[0].data || aso_out_startofpacket !== exp_q[0].sop) begin
                        fails++;
                        $display("FAIL stall_hold k=%0d got=v%0b %h want=v1 head_of_queue",
                                 k, aso_out_valid, aso_out_data);
                    end
                    tests++;
                    if (asi_in_ready !== 1'b0) begin
                        fails++;
                        $display("FAIL stall_ready k=%0d got=%0b want=0", k, asi_in_ready);
                    end
                end
                @(posedge clock_clk);
                #1;
                aso_out_ready = 1'b1;
            end
        join
        drain("backpressure");
    endtask

    task automatic test_framing();
        int pulses;
        bit leaked;
        for (int b = 0; b < 3; b++) drive_beat(b * 10, -b, 0, b == 0, b == 2);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock_clk);
            if (pkt_error) pulses++;
        end
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL short_pkt_pulse got=%0d want=1", pulses);
        end
        @(posedge clock_clk);
        #1;
        drive_beat(7, 7, 0, 0, 0);
        pulses = 0;
        leaked = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock_clk);
            if (pkt_error) pulses++;
            if (aso_out_valid) leaked = 1;
        end
        tests++;
        if (pulses != 1 || leaked) begin
            fails++;
            $display("FAIL stray_beat got=pulses%0d leaked%0b want=pulses1 leaked0", pulses, leaked);
        end
        @(posedge clock_clk);
        #1;
    endtask

    task automatic test_random();
        bit done;
        done = 0;
        fork
            begin
                for (int p = 0; p < 6; p++)
                    for (int b = 0; b < LEN; b++) begin
                        drive_beat(int'($urandom_range(262143)) - 131072,
                                   int'($urandom_range(262143)) - 131072,
                                   int'($urandom_range(63)) - 32, b == 0, b == LEN - 1);
                        if ($urandom_range(3) == 0) begin
                            @(posedge clock_clk);
                            #1;
                        end
                    end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clock_clk);
                    #1;
                    aso_out_ready = ($urandom_range(3) != 0);
                end
                aso_out_ready = 1'b1;
            end
        join
        drain("random");
    endtask

    task automatic test_reset_mid();
        drive_beat(10, 10, 0, 1, 0);
        drive_beat(20, 20, 0, 0, 0);
        asi_in_data          = {IN'(30), IN'(30), EXPW'(0)};
        asi_in_valid         = 1'b1;
        #2;
        reset_reset_n = 1'b0;
        #1;
        tests++;
        if (aso_out_valid !== 1'b0 || aso_out_data !== '0 || aso_out_endofpacket !== 1'b0 ||
            pkt_error !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid got=v%0b %h e%0b p%0b want=all0",
                     aso_out_valid, aso_out_data, aso_out_endofpacket, pkt_error);
        end
        asi_in_valid = 1'b0;
        @(posedge clock_clk);
        #1;
        reset_reset_n = 1'b1;
        @(posedge clock_clk);
        #1;
        for (int b = 0; b < LEN; b++) drive_beat(b + 1, -(b + 1), -1, b == 0, b == LEN - 1);
        drain("after_reset");
    endtask

    initial begin
        reset_reset_n        = 1'b0;
        asi_in_data          = '0;
        asi_in_valid         = 1'b0;
        asi_in_startofpacket = 1'b0;
        asi_in_endofpacket   = 1'b0;
        aso_out_ready        = 1'b1;
        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog got=timeout want=finish");
                $fatal(1, "watchdog");
            end
        join_none
        test_reset();
        test_basic();
        test_saturation();
        test_shift_clamp();
        test_backpressure();
        test_framing();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
